// File: rtl/issue_select.sv
// Issue-queue select: oldest-first pick of ready entries, bound to free FU ports.
// Grants, deallocate vector and per-port multi-cycle occupancy are registered.
module issue_select #(
    parameter int IQ_SIZE      = 64,
    parameter int ISSUE_PORTS  = 3,
    parameter int MULTI_LAT    = 4,
    parameter int IQ_SIZE_LOG2 = $clog2(IQ_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_in,
    input  logic                    flush,
    input  logic [IQ_SIZE_LOG2-1:0] iq_head,
    input  logic [IQ_SIZE-1:0]      entry_ready,
    input  logic [IQ_SIZE-1:0]      entry_multi,
    input  logic [ISSUE_PORTS-1:0]  fu_ready,
    output logic [ISSUE_PORTS-1:0]  issue_valid,
    output logic [IQ_SIZE_LOG2-1:0] issue_idx [0:ISSUE_PORTS-1],
    output logic [IQ_SIZE-1:0]      issue_clear,
    output logic [ISSUE_PORTS-1:0]  port_busy
);

    localparam int CW = $clog2(MULTI_LAT);
    localparam int KW = $clog2(ISSUE_PORTS + 1);
    localparam logic [KW-1:0] NP = KW'(ISSUE_PORTS);

    logic [CW-1:0]           busy_cnt  [ISSUE_PORTS];
    logic [IQ_SIZE-1:0]      elig;
    logic [ISSUE_PORTS-1:0]  port_ok;
    logic [IQ_SIZE_LOG2-1:0] pick_idx  [ISSUE_PORTS];
    logic [KW-1:0]           n_pick;
    logic [KW-1:0]           k;
    logic [IQ_SIZE_LOG2-1:0] idx_a;
    logic [ISSUE_PORTS-1:0]  grant;
    logic [IQ_SIZE_LOG2-1:0] grant_idx [ISSUE_PORTS];
    logic [IQ_SIZE-1:0]      grant_clr;

    // Entries being deallocated this cycle may still show ready; mask them.
    always_comb begin
        elig = entry_ready & ~issue_clear;
        for (int p = 0; p < ISSUE_PORTS; p++) begin
            port_ok[p]   = fu_ready[p] & (busy_cnt[p] == '0);
            port_busy[p] = (busy_cnt[p] != '0);
        end
    end

    always_comb begin
        n_pick    = '0;
        idx_a     = '0;
        k         = '0;
        grant     = '0;
        grant_clr = '0;
        for (int p = 0; p < ISSUE_PORTS; p++) begin
            pick_idx[p]  = '0;
            grant_idx[p] = '0;
        end
        // Walk ages from the head; wrap comes free from the index width.
        for (int a = 0; a < IQ_SIZE; a++) begin
            idx_a = iq_head + IQ_SIZE_LOG2'(a);
            if (elig[idx_a] && n_pick < NP) begin
                pick_idx[n_pick] = idx_a;
                n_pick = n_pick + KW'(1);
            end
        end
        for (int p = 0; p < ISSUE_PORTS; p++) begin
            if (port_ok[p] && k < n_pick) begin
                grant[p]               = 1'b1;
                grant_idx[p]           = pick_idx[k];
                grant_clr[pick_idx[k]] = 1'b1;
                k = k + KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid <= '0;
            issue_clear <= '0;
            for (int p = 0; p < ISSUE_PORTS; p++) begin
                issue_idx[p] <= '0;
                busy_cnt[p]  <= '0;
            end
        end else if (flush) begin
            issue_valid <= '0;
            issue_clear <= '0;
            for (int p = 0; p < ISSUE_PORTS; p++) begin
                busy_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < ISSUE_PORTS; p++) begin
                if (!stall_in && grant[p] && entry_multi[grant_idx[p]]) begin
                    busy_cnt[p] <= CW'(MULTI_LAT - 1);
                end else if (busy_cnt[p] != '0) begin
                    busy_cnt[p] <= busy_cnt[p] - CW'(1);
                end
                if (!stall_in && grant[p]) begin
                    issue_idx[p] <= grant_idx[p];
                end
            end
            issue_valid <= stall_in ? '0 : grant;
            issue_clear <= stall_in ? '0 : grant_clr;
        end
    end

endmodule

// File: tb/tb_issue_select.sv
// Scoreboard bench for issue_select: expectations queued at drive time,
// popped and compared one cycle later when the registered outputs appear.
module tb_issue_select;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        flush;
    logic [5:0]  iq_head;
    logic [63:0] entry_ready;
    logic [63:0] entry_multi;
    logic [2:0]  fu_ready;
    logic [2:0]  issue_valid;
    logic [5:0]  issue_idx [0:2];
    logic [63:0] issue_clear;
    logic [2:0]  port_busy;

    issue_select dut (
        .clk         (clk),
        .rst         (rst),
        .stall_in    (stall_in),
        .flush       (flush),
        .iq_head     (iq_head),
        .entry_ready (entry_ready),
        .entry_multi (entry_multi),
        .fu_ready    (fu_ready),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .issue_clear (issue_clear),
        .port_busy   (port_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, flush;
        logic [5:0]  head;
        logic [63:0] rdy, mul;
        logic [2:0]  fu;
    } stim_t;

    typedef struct {
        logic [2:0]      v;
        logic [2:0][5:0] idx;
        logic [2:0]      ichk;
        logic [63:0]     clr;
        logic [2:0]      busy;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic logic [63:0] b64(input int a, input int b, input int c, input int d);
        logic [63:0] r;
        r = '0;
        if (a >= 0) r = r | (64'd1 << a);
        if (b >= 0) r = r | (64'd1 << b);
        if (c >= 0) r = r | (64'd1 << c);
        if (d >= 0) r = r | (64'd1 << d);
        return r;
    endfunction

    function automatic stim_t ms(input logic r, input logic st, input logic fl,
                                 input logic [5:0] h, input logic [63:0] rd,
                                 input logic [63:0] mu, input logic [2:0] f);
        stim_t s;
        s.rst = r; s.stall = st; s.flush = fl;
        s.head = h; s.rdy = rd; s.mul = mu; s.fu = f;
        return s;
    endfunction

    function automatic exp_t me(input logic [2:0] v, input logic [5:0] i0,
                                input logic [5:0] i1, input logic [5:0] i2,
                                input logic [2:0] ic, input logic [63:0] c,
                                input logic [2:0] b);
        exp_t e;
        e.v = v; e.idx[0] = i0; e.idx[1] = i1; e.idx[2] = i2;
        e.ichk = ic; e.clr = c; e.busy = b;
        return e;
    endfunction

    task automatic drive(input stim_t s, input exp_t e);
        rst         = s.rst;
        stall_in    = s.stall;
        flush       = s.flush;
        iq_head     = s.head;
        entry_ready = s.rdy;
        entry_multi = s.mul;
        fu_ready    = s.fu;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    stim_t idle_s;
    exp_t  idle_e;

    task automatic test_reset();
        exp_t e;
        drive(ms(1, 0, 0, 0, '0, '0, 3'b111), me(0, 0, 0, 0, 3'b111, '0, 0));
        for (int r = 0; r < 6; r++) begin
            if (r > 0) drive(idle_s, idle_e);
            e = sb.pop_front();
            n_run++;
            if (issue_valid !== e.v) begin
                n_fail++;
                $display("FAIL reset[%0d] valid got %b want %b", r, issue_valid, e.v);
            end
            n_run++;
            if (issue_clear !== e.clr) begin
                n_fail++;
                $display("FAIL reset[%0d] clear got %h want %h", r, issue_clear, e.clr);
            end
            n_run++;
            if (port_busy !== e.busy) begin
                n_fail++;
                $display("FAIL reset[%0d] busy got %b want %b", r, port_busy, e.busy);
            end
            for (int p = 0; p < 3; p++) if (e.ichk[p]) begin
                n_run++;
                if (issue_idx[p] !== e.idx[p]) begin
                    n_fail++;
                    $display("FAIL reset[%0d] idx%0d got %0d want %0d", r, p, issue_idx[p], e.idx[p]);
                end
            end
        end
    endtask

    // Runs a table of rows; shared by the scenario tasks below via arrays.
    stim_t st [8];
    exp_t  ex [8];

    task automatic test_rows(input string name, input int n);
        exp_t e;
        for (int r = 0; r < n; r++) begin
            drive(st[r], ex[r]);
            e = sb.pop_front();
            n_run++;
            if (issue_valid !== e.v) begin
                n_fail++;
                $display("FAIL %s[%0d] valid got %b want %b", name, r, issue_valid, e.v);
            end
            n_run++;
            if (issue_clear !== e.clr) begin
                n_fail++;
                $display("FAIL %s[%0d] clear got %h want %h", name, r, issue_clear, e.clr);
            end
            n_run++;
            if (port_busy !== e.busy) begin
                n_fail++;
                $display("FAIL %s[%0d] busy got %b want %b", name, r, port_busy, e.busy);
            end
            for (int p = 0; p < 3; p++) if (e.ichk[p]) begin
                n_run++;
                if (issue_idx[p] !== e.idx[p]) begin
                    n_fail++;
                    $display("FAIL %s[%0d] idx%0d got %0d want %0d", name, r, p, issue_idx[p], e.idx[p]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        st[0] = ms(0, 0, 0, 62, b64(1, 5, 62, 63), '0, 3'b111);
        ex[0] = me(3'b111, 62, 63, 1, 3'b111, b64(62, 63, 1, -1), 0);
        st[1] = st[0];
        ex[1] = me(3'b001, 5, 63, 1, 3'b111, b64(5, -1, -1, -1), 0);
        st[2] = idle_s;
        ex[2] = idle_e;
        test_rows("wrap", 3);
    endtask

    task automatic test_ports();
        st[0] = ms(0, 0, 0, 0, b64(3, 4, -1, -1), '0, 3'b101);
        ex[0] = me(3'b101, 3, 0, 4, 3'b101, b64(3, 4, -1, -1), 0);
        st[1] = ms(0, 0, 0, 0, b64(6, -1, -1, -1), '0, 3'b000);
        ex[1] = idle_e;
        st[2] = ms(0, 0, 0, 0, b64(6, -1, -1, -1), '0, 3'b010);
        ex[2] = me(3'b010, 0, 6, 0, 3'b010, b64(6, -1, -1, -1), 0);
        st[3] = idle_s;
        ex[3] = idle_e;
        test_rows("ports", 4);
    endtask

    task automatic test_multi();
        st[0] = ms(0, 0, 0, 0, b64(7, -1, -1, -1), b64(7, -1, -1, -1), 3'b111);
        ex[0] = me(3'b001, 7, 0, 0, 3'b001, b64(7, -1, -1, -1), 3'b001);
        st[1] = ms(0, 0, 0, 0, b64(10, 11, -1, -1), '0, 3'b111);
        ex[1] = me(3'b110, 7, 10, 11, 3'b111, b64(10, 11, -1, -1), 3'b001);
        st[2] = ms(0, 0, 0, 0, b64(12, -1, -1, -1), '0, 3'b111);
        ex[2] = me(3'b010, 7, 12, 0, 3'b011, b64(12, -1, -1, -1), 3'b001);
        st[3] = ms(0, 0, 0, 0, b64(13, -1, -1, -1), '0, 3'b111);
        ex[3] = me(3'b010, 7, 13, 0, 3'b011, b64(13, -1, -1, -1), 3'b000);
        st[4] = ms(0, 0, 0, 0, b64(14, -1, -1, -1), '0, 3'b111);
        ex[4] = me(3'b001, 14, 0, 0, 3'b001, b64(14, -1, -1, -1), 3'b000);
        st[5] = idle_s;
        ex[5] = idle_e;
        test_rows("multi", 6);
    endtask

    task automatic test_stall();
        st[0] = ms(0, 0, 0, 0, b64(2, -1, -1, -1), b64(2, -1, -1, -1), 3'b111);
        ex[0] = me(3'b001, 2, 0, 0, 3'b001, b64(2, -1, -1, -1), 3'b001);
        st[1] = ms(0, 1, 0, 0, b64(2, 9, -1, -1), '0, 3'b111);
        ex[1] = me(3'b000, 2, 0, 0, 3'b001, '0, 3'b001);
        st[2] = st[1];
        ex[2] = me(3'b000, 0, 0, 0, 3'b000, '0, 3'b001);
        st[3] = ms(0, 0, 0, 0, b64(2, 9, -1, -1), '0, 3'b111);
        ex[3] = me(3'b110, 2, 2, 9, 3'b111, b64(2, 9, -1, -1), 3'b000);
        st[4] = idle_s;
        ex[4] = idle_e;
        test_rows("stall", 5);
    endtask

    task automatic test_flush();
        st[0] = ms(0, 0, 0, 0, b64(20, -1, -1, -1), b64(20, -1, -1, -1), 3'b010);
        ex[0] = me(3'b010, 0, 20, 0, 3'b010, b64(20, -1, -1, -1), 3'b010);
        st[1] = ms(0, 0, 0, 0, b64(21, 22, -1, -1), '0, 3'b111);
        ex[1] = me(3'b101, 21, 20, 22, 3'b111, b64(21, 22, -1, -1), 3'b010);
        st[2] = ms(0, 0, 1, 0, b64(23, 24, -1, -1), '0, 3'b111);
        ex[2] = idle_e;
        st[3] = st[0];
        ex[3] = ex[0];
        st[4] = ms(0, 1, 1, 0, b64(21, -1, -1, -1), '0, 3'b111);
        ex[4] = idle_e;
        st[5] = idle_s;
        ex[5] = idle_e;
        test_rows("flush", 6);
    endtask

    task automatic test_reset_mid();
        st[0] = ms(0, 0, 0, 0, b64(30, -1, -1, -1), b64(30, -1, -1, -1), 3'b111);
        ex[0] = me(3'b001, 30, 0, 0, 3'b001, b64(30, -1, -1, -1), 3'b001);
        st[1] = ms(1, 0, 0, 0, b64(31, -1, -1, -1), '0, 3'b111);
        ex[1] = me(3'b000, 0, 0, 0, 3'b111, '0, 3'b000);
        st[2] = idle_s;
        ex[2] = idle_e;
        test_rows("rstmid", 3);
    endtask

    initial begin
        idle_s = ms(0, 0, 0, 0, '0, '0, 3'b111);
        idle_e = me(0, 0, 0, 0, 3'b000, '0, 0);
        rst = 1'b1; stall_in = 1'b0; flush = 1'b0; iq_head = '0;
        entry_ready = '0; entry_multi = '0; fu_ready = 3'b111;
        @(posedge clk);
        #1;
        test_reset();
        test_wrap();
        test_ports();
        test_multi();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
